// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word requests under a credit
// limit, buffers in-order responses in a small FIFO and presents them to decode.
// Redirects flush the FIFO and mark all outstanding responses for discard.
module instr_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [6:0]      if_opcode,
    output logic [2:0]      if_funct3,
    output logic [6:0]      if_funct7
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = CW + 2;

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   inflight_reg, inflight_next;
    logic [CW-1:0]   drop_reg, drop_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [XLEN-1:0] fifo_pc_mem    [DEPTH];
    logic [XLEN-1:0] fifo_instr_mem [DEPTH];

    logic [SW-1:0]   credit_sum;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] rsp_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit, handshake qualification and output wiring.
    always_comb begin
        credit_sum     = SW'(count_reg) + SW'(inflight_reg) + SW'(drop_reg);
        credit_ok      = credit_sum < SW'(DEPTH);
        imem_req_valid = rst_n & credit_ok & ~redirect_valid;
        imem_req_addr  = pc_reg;
        req_fire       = imem_req_valid & imem_req_ready;
        rsp_drop       = imem_rsp_valid & (drop_reg != '0);
        push           = imem_rsp_valid & (drop_reg == '0) & (inflight_reg != '0) & ~redirect_valid;
        if_valid       = (count_reg != '0);
        pop            = if_valid & if_ready & ~redirect_valid;
        // Outstanding requests are consecutive words ending just below pc,
        // so the oldest one sits inflight words behind it.
        rsp_pc         = pc_reg - ({{(XLEN-CW){1'b0}}, inflight_reg} << 2);
        if_pc          = fifo_pc_mem[rd_ptr_reg];
        if_instr       = fifo_instr_mem[rd_ptr_reg];
        if_opcode      = if_instr[6:0];
        if_funct3      = if_instr[14:12];
        if_funct7      = if_instr[31:25];
    end

    // Next-state for PC, counters and FIFO pointers; redirect overrides all.
    always_comb begin
        pc_next       = pc_reg;
        count_next    = count_reg;
        inflight_next = inflight_reg;
        drop_next     = drop_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        if (redirect_valid) begin
            pc_next       = redirect_pc & ~XLEN'(3);
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            inflight_next = '0;
            // A response landing in this cycle belongs to the old stream and
            // consumes one of the discards it would otherwise be owed.
            drop_next     = drop_reg + inflight_reg
                          - CW'(imem_rsp_valid & ((drop_reg != '0) | (inflight_reg != '0)));
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + XLEN'(4);
            end
            inflight_next = inflight_reg + CW'(req_fire) - CW'(push);
            drop_next     = drop_reg - CW'(rsp_drop);
            count_next    = count_reg + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            count_reg    <= '0;
            inflight_reg <= '0;
            drop_reg     <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            pc_reg       <= pc_next;
            count_reg    <= count_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_mem[i]    <= '0;
                fifo_instr_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_pc_mem[wr_ptr_reg]    <= rsp_pc;
            fifo_instr_mem[wr_ptr_reg] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: cycle tables, directed redirect/reset
// sequences, and a randomized run against a program-order reference model.
module tb_instr_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;
    logic [2:0]  if_funct3;
    logic [6:0]  if_funct7;

    instr_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_opcode(if_opcode), .if_funct3(if_funct3), .if_funct7(if_funct7)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory model state: accepted addresses and the cycle each may answer.
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          last_due = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          stray = 1'b0;

    // Values sampled mid-cycle.
    logic        s_req_valid, s_fire, s_if_valid;
    logic [31:0] s_addr, s_if_pc, s_if_instr;
    logic [6:0]  s_op, s_f7;
    logic [2:0]  s_f3;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h40B5_0533;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory response, sample outputs, record handshake.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (stray) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            stray = 1'b0;
        end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_fire      = imem_req_valid & imem_req_ready;
        s_if_valid  = if_valid;
        s_if_pc     = if_pc;
        s_if_instr  = if_instr;
        s_op        = if_opcode;
        s_f3        = if_funct3;
        s_f7        = if_funct7;
        if (s_fire) begin
            int due;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        last_due = 0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (s_if_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_timeout"}, 32'(ok), 32'h1);
    endtask

    typedef struct {
        bit          rst;
        bit          mr;
        bit          ir;
        bit          ev;
        logic [31:0] ea;
        bit          eiv;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m_issue, m_exp, tgt, prev_pc, prev_instr, ei;
        bit          prev_hold, flush_next, r_redir, r_ir;
        int          pops;

        // Streaming at latency 1, then a decode stall; per-cycle expectations.
        tbl[0]  = '{1, 1, 1, 1, 32'h00, 0, 32'h0};
        tbl[1]  = '{0, 1, 1, 1, 32'h04, 0, 32'h0};
        tbl[2]  = '{0, 1, 1, 0, 32'h00, 1, 32'h0};
        tbl[3]  = '{0, 1, 1, 1, 32'h08, 1, 32'h4};
        tbl[4]  = '{0, 1, 1, 1, 32'h0C, 0, 32'h0};
        tbl[5]  = '{0, 1, 1, 0, 32'h00, 1, 32'h8};
        tbl[6]  = '{0, 1, 1, 1, 32'h10, 1, 32'hC};
        tbl[7]  = '{1, 1, 0, 1, 32'h00, 0, 32'h0};
        tbl[8]  = '{0, 1, 0, 1, 32'h04, 0, 32'h0};
        tbl[9]  = '{0, 1, 0, 0, 32'h00, 1, 32'h0};
        tbl[10] = '{0, 1, 0, 0, 32'h00, 1, 32'h0};
        tbl[11] = '{0, 1, 0, 0, 32'h00, 1, 32'h0};
        tbl[12] = '{0, 1, 1, 0, 32'h00, 1, 32'h0};
        tbl[13] = '{0, 1, 1, 1, 32'h08, 1, 32'h4};
        tbl[14] = '{0, 1, 1, 1, 32'h0C, 0, 32'h0};
        tbl[15] = '{0, 1, 1, 0, 32'h00, 1, 32'h8};
        tbl[16] = '{0, 1, 1, 1, 32'h10, 1, 32'hC};

        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst) do_reset();
            imem_req_ready = tbl[i].mr;
            if_ready       = tbl[i].ir;
            step();
            chk($sformatf("tbl%0d_req_valid", i), 32'(s_req_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].ea);
            chk($sformatf("tbl%0d_if_valid", i), 32'(s_if_valid), 32'(tbl[i].eiv));
            if (tbl[i].eiv) begin
                ei = mem_word(tbl[i].epc);
                chk($sformatf("tbl%0d_if_pc", i), s_if_pc, tbl[i].epc);
                chk($sformatf("tbl%0d_if_instr", i), s_if_instr, ei);
                chk($sformatf("tbl%0d_opcode", i), 32'(s_op), 32'(ei[6:0]));
                chk($sformatf("tbl%0d_funct3", i), 32'(s_f3), 32'(ei[14:12]));
                chk($sformatf("tbl%0d_funct7", i), 32'(s_f7), 32'(ei[31:25]));
            end
        end

        // Memory back-pressure: address and valid held until handshake.
        do_reset();
        if_ready = 1'b1;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", 32'(s_req_valid), 32'h1);
            chk("bp_hold_addr", s_addr, 32'h0);
        end
        imem_req_ready = 1'b1;
        step();
        chk("bp_fire_addr", s_addr, 32'h0);
        step();
        chk("bp_next_addr", s_addr, 32'h4);

        // Two requests in flight discarded by a redirect to 0x100.
        do_reset();
        lat_min = 3; lat_max = 3;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        chk("rd1_no_req", 32'(s_req_valid), 32'h0);
        redirect_valid = 1'b0;
        step();
        chk("rd1_fire10", {31'h0, s_fire} == 32'h1 ? s_addr : 32'hFFFF_FFFF, 32'h10);
        step();
        chk("rd1_fire14", {31'h0, s_fire} == 32'h1 ? s_addr : 32'hFFFF_FFFF, 32'h14);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        chk("rd1_no_req_redirect", 32'(s_req_valid), 32'h0);
        redirect_valid = 1'b0;
        wait_valid("rd1", 30);
        chk("rd1_if_pc", s_if_pc, 32'h100);
        chk("rd1_if_instr", s_if_instr, mem_word(32'h100));

        // Redirect coincident with a response and a pop, misaligned target.
        do_reset();
        lat_min = 1; lat_max = 1;
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        step();
        chk("rd2_no_req", 32'(s_req_valid), 32'h0);
        chk("rd2_head_valid", 32'(s_if_valid), 32'h1);
        redirect_valid = 1'b0;
        step();
        chk("rd2_flushed", 32'(s_if_valid), 32'h0);
        chk("rd2_req_valid", 32'(s_req_valid), 32'h1);
        chk("rd2_req_addr", s_addr, 32'h200);
        step();
        chk("rd2_rsp_dropped", 32'(s_if_valid), 32'h0);
        wait_valid("rd2", 10);
        chk("rd2_if_pc", s_if_pc, 32'h200);

        // Asynchronous reset mid-stream, then a stray late response.
        do_reset();
        if_ready = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_if_valid", 32'(if_valid), 32'h0);
        chk("mrst_req_valid", 32'(imem_req_valid), 32'h0);
        mq_addr.delete();
        mq_due.delete();
        last_due = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_req_ready = 1'b0;
        stray = 1'b1;
        step();
        chk("mrst_restart_addr", s_addr, 32'h0);
        step();
        chk("mrst_stray_ignored", 32'(s_if_valid), 32'h0);
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        wait_valid("mrst", 10);
        chk("mrst_if_pc", s_if_pc, 32'h0);
        chk("mrst_opcode", 32'(s_op), 32'(7'b0110011));
        chk("mrst_funct3", 32'(s_f3), 32'(3'b000));
        chk("mrst_funct7", 32'(s_f7), 32'(7'b0100000));

        // Randomized run against a program-order model of issue and delivery.
        do_reset();
        lat_min = 1; lat_max = 4;
        m_issue = 32'h0;
        m_exp = 32'h0;
        prev_hold = 1'b0;
        flush_next = 1'b0;
        pops = 0;
        prev_pc = '0;
        prev_instr = '0;
        for (int n = 0; n < 3000; n++) begin
            r_redir = ($urandom_range(24, 0) == 0);
            r_ir = ($urandom_range(9, 0) < 7);
            tgt = ($urandom_range(2, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                              : 32'($urandom_range(4095, 0));
            imem_req_ready = ($urandom_range(3, 0) != 0);
            if_ready = r_ir;
            redirect_valid = r_redir;
            redirect_pc = tgt;
            step();
            if (s_fire) begin
                chk("rnd_issue_addr", s_addr, m_issue);
                m_issue = m_issue + 32'd4;
            end
            if (r_redir) chk("rnd_no_req_on_redirect", 32'(s_req_valid), 32'h0);
            if (flush_next) chk("rnd_flush", 32'(s_if_valid), 32'h0);
            if (prev_hold) begin
                chk("rnd_hold_valid", 32'(s_if_valid), 32'h1);
                chk("rnd_hold_pc", s_if_pc, prev_pc);
                chk("rnd_hold_instr", s_if_instr, prev_instr);
            end
            if (s_if_valid && r_ir) begin
                chk("rnd_pop_pc", s_if_pc, m_exp);
                chk("rnd_pop_instr", s_if_instr, mem_word(m_exp));
                m_exp = m_exp + 32'd4;
                pops++;
            end
            chk("rnd_outstanding", 32'(mq_addr.size() <= DEPTH), 32'h1);
            if (r_redir) begin
                m_issue = tgt & 32'hFFFF_FFFC;
                m_exp = tgt & 32'hFFFF_FFFC;
            end
            flush_next = r_redir;
            prev_hold = s_if_valid && !r_ir && !r_redir;
            prev_pc = s_if_pc;
            prev_instr = s_if_instr;
        end
        redirect_valid = 1'b0;
        chk("rnd_progress", 32'(pops > 100), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
